// File: rtl/xor2_resp_checker.sv
// Response checker for an XOR_2 under test: counts samples and mismatches over a run of
// NUM_VEC accepted samples, tracks input coverage and issues a registered pass/fail verdict.
module xor2_resp_checker #(
  parameter int unsigned NUM_VEC = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             smp_valid,
  input  logic [1:0]       smp_in,
  input  logic             smp_out,
  output logic             smp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(NUM_VEC);
  // Fewer than four samples can never cover all input combinations.
  localparam bit               CanCover = (NUM_VEC >= 4);

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_smp_cnt, w_smp_cnt_d;
  logic [CNT_W-1:0] r_err_cnt, w_err_cnt_d;
  logic [3:0]       r_cov, w_cov_d;
  logic             r_fail_valid, w_fail_valid_d;
  logic [1:0]       r_fail_vec, w_fail_vec_d;
  logic             r_done, w_done_d;
  logic             r_pass, w_pass_d;
  logic             w_accept;
  logic             w_mismatch;

  assign w_accept   = (r_state == StRun) && smp_valid;
  assign w_mismatch = smp_out != (smp_in[1] ^ smp_in[0]);

  always_comb begin
    w_state_d      = r_state;
    w_smp_cnt_d    = r_smp_cnt;
    w_err_cnt_d    = r_err_cnt;
    w_cov_d        = r_cov;
    w_fail_valid_d = r_fail_valid;
    w_fail_vec_d   = r_fail_vec;
    w_done_d       = r_done;
    w_pass_d       = r_pass;

    unique case (r_state)
      StIdle, StDone: begin
        // A sample presented together with start is dropped; the run begins next cycle.
        if (start) begin
          w_state_d      = StRun;
          w_smp_cnt_d    = '0;
          w_err_cnt_d    = '0;
          w_cov_d        = '0;
          w_fail_valid_d = 1'b0;
          w_fail_vec_d   = '0;
          w_done_d       = 1'b0;
          w_pass_d       = 1'b0;
        end
      end
      StRun: begin
        if (w_accept) begin
          w_smp_cnt_d = r_smp_cnt + CNT_W'(1);
          w_cov_d     = r_cov | (4'b0001 << smp_in);
          if (w_mismatch) begin
            if (r_err_cnt != '1) begin
              w_err_cnt_d = r_err_cnt + CNT_W'(1);
            end
            if (!r_fail_valid) begin
              w_fail_valid_d = 1'b1;
              w_fail_vec_d   = smp_in;
            end
          end
          if (w_smp_cnt_d == LastCnt) begin
            w_state_d = StDone;
            w_done_d  = 1'b1;
            w_pass_d  = CanCover && (w_err_cnt_d == '0) && (w_cov_d == 4'hF);
          end
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_smp_cnt    <= '0;
      r_err_cnt    <= '0;
      r_cov        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_smp_cnt    <= w_smp_cnt_d;
      r_err_cnt    <= w_err_cnt_d;
      r_cov        <= w_cov_d;
      r_fail_valid <= w_fail_valid_d;
      r_fail_vec   <= w_fail_vec_d;
      r_done       <= w_done_d;
      r_pass       <= w_pass_d;
    end
  end

  assign smp_ready  = (r_state == StRun);
  assign busy       = (r_state == StRun);
  assign done       = r_done;
  assign pass       = r_pass;
  assign smp_cnt    = r_smp_cnt;
  assign err_cnt    = r_err_cnt;
  assign cov        = r_cov;
  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_xor2_resp_checker.sv
// Scoreboard bench for xor2_resp_checker: a default instance plus a CNT_W=2/NUM_VEC=3
// instance sharing the same stimulus; expected run results are queued as each run is driven.
module tb_xor2_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, smp_valid, smp_out;
  logic [1:0] smp_in;

  logic       smp_ready_a, busy_a, done_a, pass_a, fail_valid_a;
  logic [7:0] smp_cnt_a, err_cnt_a;
  logic [3:0] cov_a;
  logic [1:0] fail_vec_a;

  logic       smp_ready_b, busy_b, done_b, pass_b, fail_valid_b;
  logic [1:0] smp_cnt_b, err_cnt_b;
  logic [3:0] cov_b;
  logic [1:0] fail_vec_b;

  xor2_resp_checker u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .smp_valid  (smp_valid),
    .smp_in     (smp_in),
    .smp_out    (smp_out),
    .smp_ready  (smp_ready_a),
    .busy       (busy_a),
    .done       (done_a),
    .pass       (pass_a),
    .smp_cnt    (smp_cnt_a),
    .err_cnt    (err_cnt_a),
    .cov        (cov_a),
    .fail_valid (fail_valid_a),
    .fail_vec   (fail_vec_a)
  );

  xor2_resp_checker #(
    .NUM_VEC (3),
    .CNT_W   (2)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .smp_valid  (smp_valid),
    .smp_in     (smp_in),
    .smp_out    (smp_out),
    .smp_ready  (smp_ready_b),
    .busy       (busy_b),
    .done       (done_b),
    .pass       (pass_b),
    .smp_cnt    (smp_cnt_b),
    .err_cnt    (err_cnt_b),
    .cov        (cov_b),
    .fail_valid (fail_valid_b),
    .fail_vec   (fail_vec_b)
  );

  typedef struct packed {
    logic       done;
    logic       pass;
    logic [7:0] smp_cnt;
    logic [7:0] err_cnt;
    logic [3:0] cov;
    logic       fail_valid;
    logic [1:0] fail_vec;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic res_t got_a();
    return {done_a, pass_a, smp_cnt_a, err_cnt_a, cov_a, fail_valid_a, fail_vec_a};
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start     = 1'b1;
    smp_valid = 1'b0;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send(input logic [1:0] v, input logic o);
    @(negedge clk);
    start     = 1'b0;
    smp_valid = 1'b1;
    smp_in    = v;
    smp_out   = o;
  endtask

  task automatic wait_done(input bit sel_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      smp_valid = 1'b0;
      start     = 1'b0;
      if (sel_b ? done_b : done_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; smp_valid = 1'b1; smp_in = 2'd1; smp_out = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (got_a() !== '0 || busy_a !== 1'b0 || smp_ready_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: got %p busy=%b ready=%b, expected all zero", got_a(), busy_a,
               smp_ready_a);
    end
    checks++;
    if ({done_b, pass_b, smp_cnt_b, err_cnt_b, cov_b, fail_valid_b, fail_vec_b, busy_b}
        !== '0) begin
      errors++;
      $display("FAIL reset_b: got done=%b pass=%b smp=%0d err=%0d cov=%h busy=%b, expected 0",
               done_b, pass_b, smp_cnt_b, err_cnt_b, cov_b, busy_b);
    end
    rst_n = 1'b1; start = 1'b0; smp_valid = 1'b0;
    send(2'd3, 1'b0);
    @(negedge clk);
    smp_valid = 1'b0;
    checks++;
    if (smp_cnt_a !== 8'd0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid_ignored: got smp_cnt=%0d busy=%b, expected 0 0", smp_cnt_a,
               busy_a);
    end
  endtask

  task automatic test_good(input string name);
    res_t e, g;
    bit   ok;
    exp_q.push_back('{done: 1'b1, pass: 1'b1, smp_cnt: 8'd4, err_cnt: 8'd0, cov: 4'hF,
                      fail_valid: 1'b0, fail_vec: 2'd0});
    pulse_start();
    checks++;
    if (busy_a !== 1'b1 || smp_ready_a !== 1'b1 || done_a !== 1'b0 || smp_cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL %s_enter_run: got busy=%b ready=%b done=%b smp=%0d, expected 1 1 0 0",
               name, busy_a, smp_ready_a, done_a, smp_cnt_a);
    end
    send(2'd0, 1'b0); send(2'd1, 1'b1); send(2'd2, 1'b1); send(2'd3, 1'b0);
    wait_done(1'b0, ok);
    e = exp_q.pop_front();
    g = got_a();
    checks++;
    if (!ok || g !== e) begin
      errors++;
      $display("FAIL %s: got %p, expected %p", name, g, e);
    end
  endtask

  task automatic test_stuck_at0();
    res_t e, g;
    bit   ok;
    exp_q.push_back('{done: 1'b1, pass: 1'b0, smp_cnt: 8'd4, err_cnt: 8'd2, cov: 4'hF,
                      fail_valid: 1'b1, fail_vec: 2'b01});
    pulse_start();
    checks++;
    if (done_a !== 1'b0 || pass_a !== 1'b0 || smp_cnt_a !== 8'd0 || cov_a !== 4'h0) begin
      errors++;
      $display("FAIL restart_from_done: got done=%b pass=%b smp=%0d cov=%h, expected 0 0 0 0",
               done_a, pass_a, smp_cnt_a, cov_a);
    end
    for (int v = 0; v < 4; v++) send(2'(v), 1'b0);
    wait_done(1'b0, ok);
    e = exp_q.pop_front();
    g = got_a();
    checks++;
    if (!ok || g !== e) begin
      errors++;
      $display("FAIL stuck_at0: got %p, expected %p", g, e);
    end
  endtask

  task automatic test_incomplete();
    res_t e, g;
    bit   ok;
    exp_q.push_back('{done: 1'b1, pass: 1'b0, smp_cnt: 8'd4, err_cnt: 8'd0, cov: 4'b0011,
                      fail_valid: 1'b0, fail_vec: 2'd0});
    pulse_start();
    send(2'd0, 1'b0); send(2'd1, 1'b1); send(2'd1, 1'b1); send(2'd0, 1'b0);
    wait_done(1'b0, ok);
    e = exp_q.pop_front();
    g = got_a();
    checks++;
    if (!ok || g !== e) begin
      errors++;
      $display("FAIL incomplete_cov: got %p, expected %p", g, e);
    end
  endtask

  task automatic test_gapped();
    res_t e, g;
    bit   ok;
    exp_q.push_back('{done: 1'b1, pass: 1'b1, smp_cnt: 8'd4, err_cnt: 8'd0, cov: 4'hF,
                      fail_valid: 1'b0, fail_vec: 2'd0});
    pulse_start();
    send(2'd0, 1'b0);
    @(negedge clk); smp_valid = 1'b0;
    send(2'd1, 1'b1);
    @(negedge clk); smp_valid = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (smp_cnt_a !== 8'd2 || busy_a !== 1'b1 || cov_a !== 4'b0011) begin
      errors++;
      $display("FAIL start_in_run: got smp=%0d busy=%b cov=%h, expected 2 1 3", smp_cnt_a,
               busy_a, cov_a);
    end
    send(2'd2, 1'b1);
    @(negedge clk); smp_valid = 1'b0;
    send(2'd3, 1'b0);
    wait_done(1'b0, ok);
    e = exp_q.pop_front();
    g = got_a();
    checks++;
    if (!ok || g !== e) begin
      errors++;
      $display("FAIL gapped: got %p, expected %p", g, e);
    end
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    send(2'd0, 1'b0); send(2'd1, 1'b1);
    @(negedge clk);
    smp_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    checks++;
    if (busy_a !== 1'b1 || smp_cnt_a !== 8'd2) begin
      errors++;
      $display("FAIL reset_between_edges: got busy=%b smp=%0d, expected 1 2", busy_a,
               smp_cnt_a);
    end
    @(negedge clk);
    checks++;
    if (got_a() !== '0 || busy_a !== 1'b0 || smp_ready_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got %p busy=%b, expected all zero", got_a(), busy_a);
    end
    rst_n = 1'b1;
    test_good("good_after_reset");
  endtask

  task automatic test_small_counter();
    bit ok;
    pulse_start();
    send(2'd0, 1'b1); send(2'd1, 1'b0); send(2'd2, 1'b0);
    wait_done(1'b1, ok);
    checks++;
    if (!ok || err_cnt_b !== 2'd3 || smp_cnt_b !== 2'd3 || pass_b !== 1'b0 ||
        cov_b !== 4'b0111 || fail_valid_b !== 1'b1 || fail_vec_b !== 2'd0) begin
      errors++;
      $display("FAIL small_three_errs: got ok=%b err=%0d smp=%0d pass=%b cov=%h fv=%b vec=%0d,%s",
               ok, err_cnt_b, smp_cnt_b, pass_b, cov_b, fail_valid_b, fail_vec_b,
               " expected 1 3 3 0 7 1 0");
    end
    send(2'd3, 1'b1);
    @(negedge clk); smp_valid = 1'b0;
    checks++;
    if (smp_cnt_b !== 2'd3 || done_b !== 1'b1 || err_cnt_b !== 2'd3) begin
      errors++;
      $display("FAIL small_valid_in_done: got smp=%0d done=%b err=%0d, expected 3 1 3",
               smp_cnt_b, done_b, err_cnt_b);
    end
  endtask

  task automatic test_start_with_valid();
    @(negedge clk);
    start = 1'b1; smp_valid = 1'b1; smp_in = 2'd1; smp_out = 1'b1;
    @(negedge clk);
    start = 1'b0; smp_valid = 1'b0;
    checks++;
    if (smp_cnt_a !== 8'd0 || cov_a !== 4'h0 || busy_a !== 1'b1 || done_a !== 1'b0 ||
        smp_cnt_b !== 2'd0 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL start_with_valid: got a smp=%0d cov=%h busy=%b done=%b b smp=%0d busy=%b,%s",
               smp_cnt_a, cov_a, busy_a, done_a, smp_cnt_b, busy_b, " expected 0 0 1 0 0 1");
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; smp_valid = 1'b0; smp_in = 2'd0; smp_out = 1'b0;
    test_reset();
    test_good("good_run");
    test_stuck_at0();
    test_incomplete();
    test_gapped();
    test_reset_mid_run();
    test_small_counter();
    test_start_with_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
